// File: rtl/inst_r_enc_loader.sv
// R-type RV32I instruction encoder feeding a small FIFO that drains into
// instruction memory through a valid/ready write port.
module inst_r_enc_loader #(
  parameter int          DEPTH     = 4,
  parameter int          ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        op,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [4:0]        rd,
  output logic              imem_we,
  input  logic              imem_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              illegal,
  output logic [15:0]       wr_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
  localparam logic [6:0]        OPC_R    = 7'b0110011;

  logic [31:0]      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;

  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        op_legal;
  logic [31:0] word;
  logic        accept;
  logic        push;
  logic        pop;

  // Operation decode; ops 10..15 have no R-type encoding.
  always_comb begin
    funct3   = 3'b000;
    funct7   = 7'b0000000;
    op_legal = 1'b1;
    case (op)
      4'd0: funct3 = 3'b000;
      4'd1: begin funct3 = 3'b000; funct7 = 7'b0100000; end
      4'd2: funct3 = 3'b001;
      4'd3: funct3 = 3'b010;
      4'd4: funct3 = 3'b011;
      4'd5: funct3 = 3'b100;
      4'd6: funct3 = 3'b101;
      4'd7: begin funct3 = 3'b101; funct7 = 7'b0100000; end
      4'd8: funct3 = 3'b110;
      4'd9: funct3 = 3'b111;
      default: op_legal = 1'b0;
    endcase
  end

  assign word = {funct7, rs2, rs1, funct3, rd, OPC_R};

  // Full blocks the input even when a pop happens in the same cycle.
  assign in_ready   = (count_reg != FULL_CNT);
  assign imem_we    = (count_reg != '0);
  assign imem_wdata = mem[rd_ptr_reg];

  assign accept = in_valid && in_ready;
  assign push   = accept && op_legal;
  assign pop    = imem_we && imem_ready;

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  // Storage carries no reset; only pointers and occupancy define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      imem_addr  <= BASE;
      wr_count   <= '0;
      illegal    <= 1'b0;
    end else begin
      count_reg <= count_next;
      illegal   <= accept && !op_legal;
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
        imem_addr  <= imem_addr + ADDR_W'(4);
        wr_count   <= wr_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_inst_r_enc_loader.sv
// Directed plus random stimulus for inst_r_enc_loader, checked against a
// queue-based model; a second instance with a 4-bit address exercises wrap.
module tb_inst_r_enc_loader;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [3:0]  op;
  logic [4:0]  rs1, rs2, rd;
  logic        imem_ready;

  logic        in_ready_a, imem_we_a, illegal_a;
  logic [7:0]  imem_addr_a;
  logic [31:0] imem_wdata_a;
  logic [15:0] wr_count_a;

  logic        in_ready_b, imem_we_b, illegal_b;
  logic [3:0]  imem_addr_b;
  logic [31:0] imem_wdata_b;
  logic [15:0] wr_count_b;

  always #5 clk = ~clk;

  inst_r_enc_loader #(.DEPTH(DEPTH), .ADDR_W(8), .BASE_ADDR(0)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
    .op(op), .rs1(rs1), .rs2(rs2), .rd(rd),
    .imem_we(imem_we_a), .imem_ready(imem_ready), .imem_addr(imem_addr_a),
    .imem_wdata(imem_wdata_a), .illegal(illegal_a), .wr_count(wr_count_a)
  );

  inst_r_enc_loader #(.DEPTH(DEPTH), .ADDR_W(4), .BASE_ADDR(0)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
    .op(op), .rs1(rs1), .rs2(rs2), .rd(rd),
    .imem_we(imem_we_b), .imem_ready(imem_ready), .imem_addr(imem_addr_b),
    .imem_wdata(imem_wdata_b), .illegal(illegal_b), .wr_count(wr_count_b)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: pending words, total completed writes, illegal pulse.
  logic [31:0] q[$];
  int          wr_total = 0;
  bit          ill_exp  = 0;

  function automatic logic [31:0] enc(int o, int s1, int s2, int d);
    int f3_tab[10] = '{0, 0, 1, 2, 3, 4, 5, 5, 6, 7};
    int f7;
    f7 = (o == 1 || o == 7) ? 32 : 0;
    return 32'(f7 * 33554432 + s2 * 1048576 + s1 * 32768 + f3_tab[o] * 4096 + d * 128 + 51);
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic verify();
    logic [31:0] rdy, we, wc;
    rdy = (q.size() < DEPTH) ? 32'd1 : 32'd0;
    we  = (q.size() > 0) ? 32'd1 : 32'd0;
    wc  = 32'(wr_total % 65536);
    chk("in_ready_a", {31'b0, in_ready_a}, rdy);
    chk("in_ready_b", {31'b0, in_ready_b}, rdy);
    chk("we_a", {31'b0, imem_we_a}, we);
    chk("we_b", {31'b0, imem_we_b}, we);
    chk("illegal_a", {31'b0, illegal_a}, {31'b0, ill_exp});
    chk("illegal_b", {31'b0, illegal_b}, {31'b0, ill_exp});
    chk("wr_count_a", {16'b0, wr_count_a}, wc);
    chk("wr_count_b", {16'b0, wr_count_b}, wc);
    chk("addr_a", {24'b0, imem_addr_a}, 32'((wr_total * 4) % 256));
    chk("addr_b", {28'b0, imem_addr_b}, 32'((wr_total * 4) % 16));
    if (q.size() > 0) begin
      chk("wdata_a", imem_wdata_a, q[0]);
      chk("wdata_b", imem_wdata_b, q[0]);
    end
  endtask

  // One clock: check at the falling edge, advance the model on the rising edge.
  task automatic cycle(bit do_check = 1'b1);
    bit acc, pop;
    @(negedge clk);
    if (do_check) verify();
    acc = in_valid && (q.size() < DEPTH);
    pop = (q.size() > 0) && imem_ready;
    @(posedge clk);
    if (rst) begin
      q.delete();
      wr_total = 0;
      ill_exp  = 0;
    end else begin
      if (pop) begin
        void'(q.pop_front());
        wr_total++;
      end
      ill_exp = acc && (op >= 4'd10);
      if (acc && op < 4'd10) q.push_back(enc(int'(op), int'(rs1), int'(rs2), int'(rd)));
    end
    #1;
    $display("t=%0t rst=%0b v=%0b op=%0d ready=%0b we=%0b addr=%h wdata=%h cnt=%0d ill=%0b",
             $time, rst, in_valid, op, imem_ready, imem_we_a, imem_addr_a, imem_wdata_a,
             wr_count_a, illegal_a);
  endtask

  task automatic set_in(bit v, int o, int s1, int s2, int d);
    in_valid = v;
    op  = 4'(o);
    rs1 = 5'(s1);
    rs2 = 5'(s2);
    rd  = 5'(d);
  endtask

  logic [15:0] saved_cnt;
  logic [7:0]  saved_addr;

  initial begin
    rst = 1'b1;
    imem_ready = 1'b1;
    set_in(0, 0, 0, 0, 0);
    cycle(1'b0);
    rst = 1'b0;

    // Reset state, then first ADD
    set_in(1, 0, 1, 2, 3);
    cycle();
    chk("t1_we", {31'b0, imem_we_a}, 32'd1);
    chk("t1_addr", {24'b0, imem_addr_a}, 32'h00);
    chk("t1_wdata", imem_wdata_a, 32'h002081B3);

    // Back-to-back encodings
    set_in(1, 1, 6, 7, 5);
    cycle();
    chk("t2_wr_count", {16'b0, wr_count_a}, 32'd1);
    chk("t2_addr", {24'b0, imem_addr_a}, 32'h04);
    chk("t2_sub", imem_wdata_a, 32'h407302B3);
    chk("t2_rs2_field", {27'b0, imem_wdata_a[24:20]}, 32'd7);
    chk("t2_rs1_field", {27'b0, imem_wdata_a[19:15]}, 32'd6);
    chk("t2_rd_field", {27'b0, imem_wdata_a[11:7]}, 32'd5);
    set_in(1, 7, 31, 31, 31);
    cycle();
    chk("t2_sra", imem_wdata_a, 32'h41FFDFB3);
    set_in(1, 9, 0, 0, 0);
    cycle();
    chk("t2_and", imem_wdata_a, 32'h00007033);
    set_in(0, 0, 0, 0, 0);
    cycle();

    // Backpressure: fill, hold a fifth request, then release
    imem_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      set_in(1, k + 2, k + 1, k + 9, k + 17);
      cycle();
    end
    chk("bp_full_ready", {31'b0, in_ready_a}, 32'd0);
    saved_cnt = wr_count_a;
    set_in(1, 5, 3, 4, 8);
    cycle();
    cycle();
    chk("bp_held_cnt", {16'b0, wr_count_a}, {16'b0, saved_cnt});
    imem_ready = 1'b1;
    cycle();
    chk("bp_ready_after_pop", {31'b0, in_ready_a}, 32'd1);
    cycle();
    set_in(0, 0, 0, 0, 0);
    repeat (6) cycle();

    // Illegal ops, single and back-to-back
    saved_cnt  = wr_count_a;
    saved_addr = imem_addr_a;
    set_in(1, 12, 1, 1, 1);
    cycle();
    set_in(0, 0, 0, 0, 0);
    chk("ill_pulse", {31'b0, illegal_a}, 32'd1);
    chk("ill_no_push", {31'b0, imem_we_a}, 32'd0);
    cycle();
    chk("ill_pulse_end", {31'b0, illegal_a}, 32'd0);
    chk("ill_cnt_hold", {16'b0, wr_count_a}, {16'b0, saved_cnt});
    chk("ill_addr_hold", {24'b0, imem_addr_a}, {24'b0, saved_addr});
    set_in(1, 15, 0, 0, 0);
    cycle();
    chk("ill_b2b_1", {31'b0, illegal_a}, 32'd1);
    cycle();
    chk("ill_b2b_2", {31'b0, illegal_a}, 32'd1);
    set_in(0, 0, 0, 0, 0);
    cycle();

    // Illegal op while full is refused
    imem_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      set_in(1, 0, k, k, k);
      cycle();
    end
    set_in(1, 12, 0, 0, 0);
    cycle();
    chk("ill_full_refused", {31'b0, illegal_a}, 32'd0);
    set_in(0, 0, 0, 0, 0);
    imem_ready = 1'b1;
    repeat (5) cycle();

    // Reset with three words buffered
    imem_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      set_in(1, 8, k, k + 1, k + 2);
      cycle();
    end
    set_in(0, 0, 0, 0, 0);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("rst_we", {31'b0, imem_we_a}, 32'd0);
    chk("rst_addr", {24'b0, imem_addr_a}, 32'd0);
    chk("rst_cnt", {16'b0, wr_count_a}, 32'd0);
    chk("rst_ready", {31'b0, in_ready_a}, 32'd1);

    // Address wrap on the 4-bit instance: five consecutive writes
    imem_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      set_in(1, 0, k, k, k);
      cycle();
    end
    set_in(0, 0, 0, 0, 0);
    cycle();
    chk("wrap_addr_b", {28'b0, imem_addr_b}, 32'h4);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      rst        = ($urandom % 100) == 0;
      imem_ready = ($urandom % 4) != 0;
      set_in(($urandom % 3) != 0, int'($urandom % 16), int'($urandom % 32),
             int'($urandom % 32), int'($urandom % 32));
      cycle();
    end
    rst = 1'b0;
    imem_ready = 1'b1;
    set_in(0, 0, 0, 0, 0);
    repeat (6) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
